// File: rtl/count_fsm_param.sv
// Parametrised up/down counter with direction FSM, wrap/saturate limits and a wrap pulse.
// Optional sticky overflow flag (Clear_ovf/Overflow) under macro COUNT_FSM_STICKY_OVF_EN.
module count_fsm_param #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 15,
  parameter int unsigned MODE      = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Count_up,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_val,
`ifdef COUNT_FSM_STICKY_OVF_EN
  input  logic             Clear_ovf,
  output logic             Overflow,
`endif
  output logic [WIDTH-1:0] Count,
  output logic [1:0]       State,
  output logic             Terminal,
  output logic             Wrapped
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam bit               SAT   = (MODE == 1);

  if (WIDTH < 2 || MAX_COUNT < 1 || (MAX_COUNT >> WIDTH) != 0 || MODE > 1) begin : g_bad_param
    $error("count_fsm_param: illegal WIDTH/MAX_COUNT/MODE combination");
  end

  state_t           state_q;
  logic             at_limit_c;
  logic [WIDTH-1:0] step_c;
  logic [WIDTH-1:0] wrap_c;
  state_t           dir_c;

  // Limit is judged against the requested direction, so it doubles as Terminal.
  assign at_limit_c = Count_up ? (Count == MAX_V) : (Count == '0);
  assign step_c     = Count_up ? (Count + WIDTH'(1)) : (Count - WIDTH'(1));
  assign wrap_c     = Count_up ? '0 : MAX_V;
  assign dir_c      = Count_up ? UP : DOWN;

  assign Terminal = at_limit_c;
  assign State    = state_q;

  // Every state steps the same way once enabled: IDLE/HALT enter the direction
  // state on the stepping edge, UP/DOWN flip direction without a dead cycle,
  // and HALT simply re-enters HALT while the direction still points into the limit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Count   <= '0;
      state_q <= IDLE;
      Wrapped <= 1'b0;
    end else if (Load) begin
      Count   <= (Load_val > MAX_V) ? MAX_V : Load_val;
      state_q <= IDLE;
      Wrapped <= 1'b0;
    end else if (!Enable) begin
      Wrapped <= 1'b0;
    end else if (!at_limit_c) begin
      Count   <= step_c;
      state_q <= dir_c;
      Wrapped <= 1'b0;
    end else if (SAT) begin
      state_q <= HALT;
      Wrapped <= 1'b0;
    end else begin
      Count   <= wrap_c;
      state_q <= dir_c;
      Wrapped <= 1'b1;
    end
  end

`ifdef COUNT_FSM_STICKY_OVF_EN
  logic ovf_set_c;

  // A wrap, or the first edge that lands in HALT; set beats clear.
  assign ovf_set_c = !Load && Enable && at_limit_c && (!SAT || (state_q != HALT));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Overflow <= 1'b0;
    end else if (ovf_set_c) begin
      Overflow <= 1'b1;
    end else if (Clear_ovf) begin
      Overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/count_fsm_param.md
Name: count_fsm_param

Overview:
Parametrised up/down counter FSM; next generation of the 4-bit CountFSM.
- Width and modulus are configurable.
- Supports a count enable, a synchronous load, and wrap or saturate mode at the limits.
- Keeps the explicit direction FSM and adds a one-cycle wrap indicator.
- Drives tick/sequence counts in lab datapaths and is driven by the same style of Clk/Reset/Count_up stimulus benches.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX_COUNT, 15, terminal value; count range 0..MAX_COUNT; must satisfy 1 <= MAX_COUNT <= 2^WIDTH-1
MODE, 0, 0 = wrap at limits, 1 = saturate at limits

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Enable  input  1  count enable, sampled at rising Clk
Count_up  input  1  direction: 1 = up, 0 = down
Load  input  1  synchronous load strobe
Load_val  input  WIDTH  value loaded when Load=1
Count  output  WIDTH  current count (registered)
State  output  2  FSM state: IDLE=0, UP=1, DOWN=2, HALT=3 (registered)
Terminal  output  1  combinational: (Count_up & Count==MAX_COUNT) | (~Count_up & Count==0)
Wrapped  output  1  registered one-cycle pulse on a wrap

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset state: while Reset=1, Count=0, State=IDLE, Wrapped=0, independent of Clk. Reset asserted mid-count takes effect immediately. The first enabled edge after deassert counts from 0.
- Priority per edge: Reset > Load > Enable.
- Load:
  - Count <= Load_val, clamped to MAX_COUNT if Load_val > MAX_COUNT.
  - State <= IDLE, Wrapped <= 0.
  - Load wins over Enable on the same edge; no count occurs that cycle.
- Enable=0: Count, State hold; Wrapped <= 0.
- Latency: one edge per step, no dead cycles on start or direction change.
- IDLE, Enable=1: move to UP if Count_up=1, else DOWN. Count steps on this same edge.
- UP, Enable=1:
  - Count_up=1: count up.
  - Count_up=0: move to DOWN and decrement on the same edge.
- DOWN: symmetric to UP.
- Step rules, MODE=0 (wrap):
  - Up at MAX_COUNT -> 0, Wrapped=1 for one cycle.
  - Down at 0 -> MAX_COUNT, Wrapped=1.
  - Otherwise +1 / -1, Wrapped=0.
- Step rules, MODE=1 (saturate):
  - Up at MAX_COUNT: Count holds, State <= HALT.
  - Down at 0: Count holds, State <= HALT.
  - Wrapped is never asserted in MODE=1.
- HALT (MODE=1 only):
  - Count holds while the direction points into the limit.
  - With Enable=1 and the direction pointing away from the limit, move to UP/DOWN and step on the same edge.
  - Load exits to IDLE.
  - HALT is unreachable in MODE=0.
- Arithmetic: Count never leaves 0..MAX_COUNT in any mode. Non-power-of-two MAX_COUNT wraps at MAX_COUNT, not at 2^WIDTH-1.
- Terminal: purely combinational from Count and Count_up, valid in every state including IDLE.

Optional Feature:
Macro COUNT_FSM_STICKY_OVF_EN.
- Defined:
  - Adds input Clear_ovf (1 bit) and output Overflow (1 bit, registered, reset 0).
  - Overflow is set on any wrap (MODE=0) or HALT entry (MODE=1).
  - Overflow holds until an edge with Clear_ovf=1.
  - Set wins over clear on the same edge.
  - Load does not clear Overflow.
- Undefined: both ports absent; no extra logic.

Test Plan:
- Reset and start: Clk period 10, Reset pulse 1..2 ns, Enable=1, Count_up=1 -> Count=0 and State=IDLE during reset; after the first edge Count=1, State=UP; Count=15 after 15 edges; next edge Count=0 with Wrapped=1 for exactly one cycle (WIDTH=4, MAX_COUNT=15, MODE=0).
- Direction flip: from Count=5 in UP, drop Count_up -> same edge gives Count=4, State=DOWN; at 0 with Count_up=0 the next edge gives Count=15, Wrapped=1; Terminal=1 at Count=0 while Count_up=0.
- Modulus and clamp: MAX_COUNT=9 -> up sequence ...8,9,0; Load with Load_val=13 -> Count=9, State=IDLE; Load and Enable together -> load only, no increment.
- Saturate: MODE=1, count up to 15 -> stays 15, State=HALT, Wrapped stays 0; Count_up=0 with Enable=1 -> Count=14, State=DOWN.
- Async reset mid-count: assert Reset between edges at Count=7 -> Count=0 before the next Clk edge; Enable=0 holds Count and State unchanged across 3 edges.
- With COUNT_FSM_STICKY_OVF_EN defined: a wrap sets Overflow=1, which stays 1 across 5 further edges; Clear_ovf=1 clears it; Clear_ovf on a wrap edge -> Overflow remains 1.
